// File: rtl/fpu.sv
// bfloat16 add/sub/mul/div unit: round-to-nearest-even, flush-to-zero,
// exponent overflow flag, one registered result per clock.
module fpu (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  mode_i,
   input  logic [15:0] in1_i,
   input  logic [15:0] in2_i,
   output logic [15:0] out_o,
   output logic        overflow_o
);
   localparam int unsigned EW   = 8;        // exponent bits
   localparam int unsigned FW   = 7;        // fraction bits
   localparam int unsigned SW   = FW + 1;   // significand incl. hidden one
   localparam int unsigned XW   = SW + 3;   // significand + guard/round/sticky
   localparam int unsigned NW   = 11;       // two's-complement working exponent
   localparam int unsigned QW   = 12;       // quotient bits (integer bit + 11)
   localparam int unsigned BIAS = 127;
   localparam logic [15:0] QNAN    = 16'h7FC0;
   localparam logic [14:0] INF_MAG = 15'h7F80;

   logic          sa, sb, sb_eff, sx;
   logic [EW-1:0] ea, eb;
   logic [FW-1:0] fa, fb;
   logic          a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
   logic          op_add, op_sub, op_mul, op_div;

   assign op_add = (mode_i == 4'b0001);
   assign op_sub = (mode_i == 4'b0010);
   assign op_mul = (mode_i == 4'b0100);
   assign op_div = (mode_i == 4'b1000);

   assign sa     = in1_i[15];
   assign ea     = in1_i[14:7];
   assign fa     = in1_i[6:0];
   assign sb     = in2_i[15];
   assign eb     = in2_i[14:7];
   assign fb     = in2_i[6:0];
   assign sb_eff = sb ^ op_sub;
   assign sx     = sa ^ sb;

   assign a_zero = (ea == '0);
   assign a_inf  = (ea == '1) && (fa == '0);
   assign a_nan  = (ea == '1) && (fa != '0);
   assign b_zero = (eb == '0);
   assign b_inf  = (eb == '1) && (fb == '0);
   assign b_nan  = (eb == '1) && (fb != '0);

   // Rounds an 8-bit significand with guard/sticky to nearest-even and packs;
   // returns {overflow, result}.
   function automatic logic [16:0] round_pack(input logic s, input logic [NW-1:0] e,
                                              input logic [SW-1:0] sig, input logic g,
                                              input logic st);
      logic [SW:0]   sig_r;
      logic [NW-1:0] e_r;
      sig_r = {1'b0, sig} + (SW+1)'(g & (st | sig[0]));
      e_r   = e + NW'(sig_r[SW]);
      if (!e_r[NW-1] && (e_r >= NW'(255)))
         return {1'b1, s, INF_MAG};
      if (e_r[NW-1] || (e_r == '0))
         return {1'b0, s, 15'h0000};
      return {1'b0, s, e_r[EW-1:0], sig_r[FW-1:0]};
   endfunction

   // Add/sub of magnitudes: align smaller operand, add/subtract, normalise.
   logic          a_big, add_sl, add_eff_sub, add_cancel, add_found;
   logic [EW-1:0] add_el, add_diff;
   logic [SW-1:0] add_sig_l, add_sig_s, add_sig;
   logic [XW-1:0] add_ext_s, add_shift, add_lost, add_al_s, add_norm;
   logic [XW:0]   add_sum;
   logic [3:0]    add_lz;
   logic [NW-1:0] add_exp;
   logic          add_g, add_st;

   always_comb begin : add_path
      a_big       = (in1_i[14:0] >= in2_i[14:0]);
      add_sl      = a_big ? sa : sb_eff;
      add_el      = a_big ? ea : eb;
      add_diff    = a_big ? (ea - eb) : (eb - ea);
      add_sig_l   = {1'b1, a_big ? fa : fb};
      add_sig_s   = {1'b1, a_big ? fb : fa};
      add_eff_sub = sa ^ sb_eff;
      add_ext_s   = {add_sig_s, 3'b000};
      add_shift   = add_ext_s >> add_diff;
      add_lost    = add_ext_s & ~({XW{1'b1}} << add_diff);
      // once shifted past the sticky position the smaller operand is pure sticky
      if (add_diff >= EW'(XW))
         add_al_s = XW'(1);
      else
         add_al_s = {add_shift[XW-1:1], add_shift[0] | (|add_lost)};

      if (add_eff_sub)
         add_sum = {1'b0, add_sig_l, 3'b000} - {1'b0, add_al_s};
      else
         add_sum = {1'b0, add_sig_l, 3'b000} + {1'b0, add_al_s};
      add_cancel = (add_sum == '0);

      add_lz    = '0;
      add_found = 1'b0;
      for (int i = int'(XW) - 1; i >= 0; i--) begin
         if (!add_found && add_sum[i]) begin
            add_lz    = 4'(int'(XW) - 1 - i);
            add_found = 1'b1;
         end
      end
      add_norm = add_sum[XW-1:0] << add_lz;

      if (add_sum[XW]) begin
         add_sig = add_sum[XW:4];
         add_g   = add_sum[3];
         add_st  = |add_sum[2:0];
         add_exp = NW'(add_el) + NW'(1);
      end else begin
         add_sig = add_norm[XW-1:3];
         add_g   = add_norm[2];
         add_st  = |add_norm[1:0];
         add_exp = NW'(add_el) - NW'(add_lz);
      end
   end

   // Multiply: 8x8 significand product, product in [1,4).
   logic [2*SW-1:0] mul_prod;
   logic [SW-1:0]   mul_sig;
   logic [NW-1:0]   mul_exp;
   logic            mul_g, mul_st;

   always_comb begin : mul_path
      mul_prod = (2*SW)'({1'b1, fa}) * (2*SW)'({1'b1, fb});
      mul_exp  = NW'(ea) + NW'(eb) - NW'(BIAS) + NW'(mul_prod[2*SW-1]);
      if (mul_prod[2*SW-1]) begin
         mul_sig = mul_prod[15:8];
         mul_g   = mul_prod[7];
         mul_st  = |mul_prod[6:0];
      end else begin
         mul_sig = mul_prod[14:7];
         mul_g   = mul_prod[6];
         mul_st  = |mul_prod[5:0];
      end
   end

   // Divide: restoring, integer quotient bit first, quotient in (0.5,2).
   logic [QW-1:0] div_q;
   logic [SW+1:0] div_rem;
   logic [SW-1:0] div_sig;
   logic [NW-1:0] div_exp;
   logic          div_g, div_st;

   always_comb begin : div_path
      div_rem = {2'b00, 1'b1, fa};
      div_q   = '0;
      for (int i = int'(QW) - 1; i >= 0; i--) begin
         if (div_rem >= {2'b00, 1'b1, fb}) begin
            div_q[i] = 1'b1;
            div_rem  = div_rem - {2'b00, 1'b1, fb};
         end
         if (i > 0)
            div_rem = div_rem << 1;
      end
      if (div_q[QW-1]) begin
         div_sig = div_q[11:4];
         div_g   = div_q[3];
         div_st  = (|div_q[2:0]) | (|div_rem);
         div_exp = NW'(ea) - NW'(eb) + NW'(BIAS);
      end else begin
         div_sig = div_q[10:3];
         div_g   = div_q[2];
         div_st  = (|div_q[1:0]) | (|div_rem);
         div_exp = NW'(ea) - NW'(eb) + NW'(BIAS - 1);
      end
   end

   // Special-operand resolution and final result selection.
   logic [15:0] out_d, out_q;
   logic        ovf_d, ovf_q;

   always_comb begin : result_sel
      out_d = 16'h0000;
      ovf_d = 1'b0;
      if (op_add || op_sub) begin
         if (a_nan || b_nan)            out_d = QNAN;
         else if (a_inf && b_inf)       out_d = (sa != sb_eff) ? QNAN : {sa, INF_MAG};
         else if (a_inf)                out_d = {sa, INF_MAG};
         else if (b_inf)                out_d = {sb_eff, INF_MAG};
         else if (a_zero && b_zero)     out_d = {sa & sb_eff, 15'h0000};
         else if (a_zero)               out_d = {sb_eff, in2_i[14:0]};
         else if (b_zero)               out_d = in1_i;
         else if (add_cancel)           out_d = 16'h0000;
         else {ovf_d, out_d} = round_pack(add_sl, add_exp, add_sig, add_g, add_st);
      end else if (op_mul) begin
         if (a_nan || b_nan)                                 out_d = QNAN;
         else if ((a_inf && b_zero) || (a_zero && b_inf))    out_d = QNAN;
         else if (a_inf || b_inf)                            out_d = {sx, INF_MAG};
         else if (a_zero || b_zero)                          out_d = {sx, 15'h0000};
         else {ovf_d, out_d} = round_pack(sx, mul_exp, mul_sig, mul_g, mul_st);
      end else if (op_div) begin
         if (a_nan || b_nan)                                 out_d = QNAN;
         else if ((a_zero && b_zero) || (a_inf && b_inf))    out_d = QNAN;
         else if (a_inf)                                     out_d = {sx, INF_MAG};
         else if (b_inf)                                     out_d = {sx, 15'h0000};
         else if (b_zero)                                    out_d = {sx, INF_MAG};
         else if (a_zero)                                    out_d = {sx, 15'h0000};
         else {ovf_d, out_d} = round_pack(sx, div_exp, div_sig, div_g, div_st);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_q <= 16'h0000;
         ovf_q <= 1'b0;
      end else begin
         out_q <= out_d;
         ovf_q <= ovf_d;
      end
   end

   assign out_o      = out_q;
   assign overflow_o = ovf_q;

endmodule

// File: tb/tb_fpu.sv
// Bench for fpu: directed cases plus randomized streaming checked against a
// model that computes in double precision and rounds to bfloat16.
module tb_fpu;
   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  mode_i;
   logic [15:0] in1_i, in2_i;
   logic [15:0] out_o;
   logic        overflow_o;

   int total = 0;
   int bad   = 0;

   localparam logic [3:0] ADD = 4'b0001;
   localparam logic [3:0] SUB = 4'b0010;
   localparam logic [3:0] MUL = 4'b0100;
   localparam logic [3:0] DIV = 4'b1000;

   fpu dut (
      .clk        (clk),
      .rst        (rst),
      .mode_i     (mode_i),
      .in1_i      (in1_i),
      .in2_i      (in2_i),
      .out_o      (out_o),
      .overflow_o (overflow_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // bfloat16 -> double, with exponent-0 inputs flushed to signed zero
   function automatic real bf2real(input logic [15:0] x);
      logic [63:0] b;
      if (x[14:7] == 8'h00)
         b = {x[15], 63'd0};
      else if (x[14:7] == 8'hFF)
         b = {x[15], 11'h7FF, x[6:0], 45'd0};
      else
         b = {x[15], 11'(x[14:7]) + 11'd896, x[6:0], 45'd0};
      return $bitstoreal(b);
   endfunction

   // Exact-ish real arithmetic then one RNE rounding to 8 significand bits.
   task automatic model(input logic [3:0] m, input logic [15:0] a, input logic [15:0] b,
                        output logic [15:0] r, output logic ov);
      real         x, y, z;
      logic [63:0] d;
      int          e;
      logic [7:0]  k;
      logic        g, st;
      r  = 16'h0000;
      ov = 1'b0;
      x  = bf2real(a);
      y  = bf2real(b);
      case (m)
         ADD:     z = x + y;
         SUB:     z = x - y;
         MUL:     z = x * y;
         DIV:     z = x / y;
         default: return;
      endcase
      d = $realtobits(z);
      if (d[62:52] == 11'h7FF) begin
         r = (d[51:0] != 52'd0) ? 16'h7FC0 : {d[63], 15'h7F80};
         return;
      end
      if (d[62:0] == 63'd0) begin
         r = {d[63], 15'h0000};
         return;
      end
      e  = int'(d[62:52]) - 896;
      k  = {1'b1, d[51:45]};
      g  = d[44];
      st = |d[43:0];
      if (g && (st || k[0])) begin
         if (k == 8'hFF) begin
            k = 8'h80;
            e++;
         end else begin
            k++;
         end
      end
      if (e >= 255) begin
         r  = {d[63], 15'h7F80};
         ov = 1'b1;
      end else if (e < 1) begin
         r = {d[63], 15'h0000};
      end else begin
         r = {d[63], 8'(e), k[6:0]};
      end
   endtask

   function automatic logic [15:0] rand_val();
      logic [15:0] v;
      v = 16'($urandom);
      case ($urandom_range(0, 19))
         0:       v[14:7] = 8'h00;
         1:       v[14:7] = 8'hFF;
         2:       v[14:7] = 8'($urandom_range(240, 254));
         3:       v[14:7] = 8'($urandom_range(1, 12));
         default: ;
      endcase
      return v;
   endfunction

   task automatic cyc(input logic [3:0] m, input logic [15:0] a, input logic [15:0] b);
      mode_i = m;
      in1_i  = a;
      in2_i  = b;
      @(posedge clk);
      #1;
   endtask

   task automatic dir(input string name, input logic [3:0] m, input logic [15:0] a,
                      input logic [15:0] b, input logic [15:0] er, input logic eo);
      cyc(m, a, b);
      check($sformatf("%s out", name), out_o, er);
      check($sformatf("%s ovf", name), 16'(overflow_o), 16'(eo));
   endtask

   task automatic rnd(input logic [3:0] m, input logic [15:0] a, input logic [15:0] b);
      logic [15:0] er;
      logic        eo;
      cyc(m, a, b);
      model(m, a, b, er, eo);
      check($sformatf("m=%b a=%h b=%h out", m, a, b), out_o, er);
      check($sformatf("m=%b a=%h b=%h ovf", m, a, b), 16'(overflow_o), 16'(eo));
   endtask

   logic [3:0]  modes [4] = '{ADD, SUB, MUL, DIV};
   logic [3:0]  rm;
   logic [15:0] ra, rb;

   initial begin
      rst    = 1'b1;
      mode_i = ADD;
      in1_i  = 16'h1234;
      in2_i  = 16'h5678;
      cyc(MUL, 16'h7F7F, 16'h4000);
      check("reset out", out_o, 16'h0000);
      check("reset ovf", 16'(overflow_o), 16'h0000);
      rst = 1'b0;

      dir("first add",   ADD, 16'h3F80, 16'h4000, 16'h4040, 1'b0);
      dir("add 1+3",     ADD, 16'h3F80, 16'h4040, 16'h4080, 1'b0);
      dir("sub 1-3",     SUB, 16'h3F80, 16'h4040, 16'hC000, 1'b0);
      dir("mul 1*3",     MUL, 16'h3F80, 16'h4040, 16'h4040, 1'b0);
      dir("div 1/3",     DIV, 16'h3F80, 16'h4040, 16'h3EAB, 1'b0);
      dir("mul 2*3",     MUL, 16'h4000, 16'h4040, 16'h40C0, 1'b0);
      dir("tie even",    ADD, 16'h3F80, 16'h3B80, 16'h3F80, 1'b0);
      dir("above half",  ADD, 16'h3F80, 16'h3BC0, 16'h3F81, 1'b0);
      dir("tie odd up",  ADD, 16'h3F81, 16'h3B80, 16'h3F82, 1'b0);
      dir("cancel",      SUB, 16'h3F80, 16'h3F80, 16'h0000, 1'b0);
      dir("mul ovf",     MUL, 16'h7F7F, 16'h4000, 16'h7F80, 1'b1);
      dir("add ovf",     ADD, 16'h7F7F, 16'h7F7F, 16'h7F80, 1'b1);
      dir("ovf clear",   ADD, 16'h3F80, 16'h4000, 16'h4040, 1'b0);
      dir("neg add ovf", ADD, 16'hFF7F, 16'hFF7F, 16'hFF80, 1'b1);
      dir("x/0",         DIV, 16'h3F80, 16'h0000, 16'h7F80, 1'b0);
      dir("-x/0",        DIV, 16'hBF80, 16'h0000, 16'hFF80, 1'b0);
      dir("0/0",         DIV, 16'h0000, 16'h0000, 16'h7FC0, 1'b0);
      dir("inf*0",       MUL, 16'h7F80, 16'h0000, 16'h7FC0, 1'b0);
      dir("inf-inf",     ADD, 16'h7F80, 16'hFF80, 16'h7FC0, 1'b0);
      dir("inf/inf",     DIV, 16'h7F80, 16'hFF80, 16'h7FC0, 1'b0);
      dir("nan in",      MUL, 16'h7FA0, 16'h3F80, 16'h7FC0, 1'b0);
      dir("ftz in",      ADD, 16'h0001, 16'h0000, 16'h0000, 1'b0);
      dir("x/inf",       DIV, 16'hBF80, 16'h7F80, 16'h8000, 1'b0);
      dir("ftz mul",     MUL, 16'h8080, 16'h0080, 16'h8000, 1'b0);
      dir("inf+x",       SUB, 16'h3F80, 16'h7F80, 16'hFF80, 1'b0);
      dir("bad mode 0",  4'b0000, 16'h3F80, 16'h4000, 16'h0000, 1'b0);
      dir("bad mode 2b", 4'b0011, 16'h3F80, 16'h4000, 16'h0000, 1'b0);

      // reset must override an overflowing result already at the inputs
      rst = 1'b1;
      cyc(MUL, 16'h7F7F, 16'h4000);
      check("reset mid out", out_o, 16'h0000);
      check("reset mid ovf", 16'(overflow_o), 16'h0000);
      rst = 1'b0;

      foreach (modes[i]) begin
         for (int n = 0; n < 10; n++)
            rnd(modes[i], rand_val(), rand_val());
      end

      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 19) == 0)
            rm = 4'($urandom);
         else
            rm = 4'(1 << $urandom_range(0, 3));
         ra = rand_val();
         rb = rand_val();
         if ($urandom_range(0, 3) == 0)
            rb[14:7] = ra[14:7];
         rnd(rm, ra, rb);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
